// File: rtl/tx_sched_pkg.sv
// Shared types and counter widths for the transmit scheduler.
package tx_sched_pkg;

    localparam int WD_W  = 16;  // ACTIVE watchdog width
    localparam int GAP_W = 8;   // inter-frame gap counter width
    localparam int FC_W  = 16;  // completed-frame counter width

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE,
        GAP
    } state_t;

endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// Two-way round-robin pick with a last-grant pointer.
module rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       update,
    input  logic       granted,
    output logic       pick
);

    // Requester that owned the previous frame; reset value makes 0 win first.
    logic last;

    // A lone valid wins outright; a tie goes to the requester opposite the last grant.
    always_comb begin
        pick = ~last;
        if (valid == 2'b01) begin
            pick = 1'b0;
        end else if (valid == 2'b10) begin
            pick = 1'b1;
        end
    end

    // Pointer moves only when the scheduler commits a grant (LOAD cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= granted;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Frame scheduler: arbitrates two word sources onto a modulator, runs a
// per-frame watchdog, and enforces a fixed idle gap between frames.
import tx_sched_pkg::*;

module tx_scheduler #(
    parameter int DATA_SIZE      = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [DATA_SIZE-1:0] req_data0,
    input  logic [DATA_SIZE-1:0] req_data1,
    output logic [1:0]           req_ready,
    output logic [DATA_SIZE-1:0] mod_data,
    output logic                 mod_enable,
    input  logic                 mod_done,
    input  logic                 clr_err,
    output logic                 busy,
    output logic                 grant,
    output logic                 err_timeout,
    output logic [FC_W-1:0]      frame_count
);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [FC_W-1:0]        fc_d;
    logic                   err_d;
    logic [DATA_SIZE-1:0]   md_d;
    logic [1:0]             rr_d;
    logic                   grant_d;
    logic                   pick;

    rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (req_valid),
        .update  (state_q == LOAD),
        .granted (grant),
        .pick    (pick)
    );

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        fc_d    = frame_count;
        err_d   = clr_err ? 1'b0 : err_timeout;
        md_d    = mod_data;
        rr_d    = '0;
        grant_d = grant;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = LOAD;
                    grant_d = pick;
                    rr_d    = pick ? 2'b10 : 2'b01;
                    md_d    = pick ? req_data1 : req_data0;
                end
            end
            LOAD: begin
                state_d = ACTIVE;
                wd_d    = '0;
            end
            ACTIVE: begin
                if (mod_done) begin
                    state_d = GAP;
                    gap_d   = '0;
                    if (frame_count != '1) begin
                        fc_d = frame_count + 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    // Timeout set takes priority over a simultaneous clr_err.
                    state_d = GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and outputs; enable/busy are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q        <= '0;
            gap_q       <= '0;
            frame_count <= '0;
            err_timeout <= 1'b0;
            mod_data    <= '0;
            req_ready   <= '0;
            grant       <= 1'b0;
            mod_enable  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            frame_count <= fc_d;
            err_timeout <= err_d;
            mod_data    <= md_d;
            req_ready   <= rr_d;
            grant       <= grant_d;
            mod_enable  <= (state_d == ACTIVE);
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: stimulus pushes per-frame expectations
// derived from the arbitration/watchdog rules; a monitor checks each frame.
module tb_tx_scheduler;

    localparam int GAP = 8;
    localparam int TO  = 120;

    typedef struct {
        logic [1:0]  ready;
        logic        grant;
        logic [15:0] data;
        int          active_len;
        logic        err_active;
        logic        err_gap;
        logic [15:0] fc;
        bit          abort;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data0, req_data1;
    logic [1:0]  req_ready;
    logic [15:0] mod_data;
    logic        mod_enable;
    logic        mod_done;
    logic        clr_err;
    logic        busy;
    logic        grant;
    logic        err_timeout;
    logic [15:0] frame_count;

    int vectors     = 0;
    int miscompares = 0;

    exp_t        exp_q[$];
    logic [1:0]  pending = 2'b00;
    logic [15:0] pdata [2];
    logic        last_m = 1'b1;
    logic        err_m  = 1'b0;
    logic [15:0] fc_m   = '0;

    tx_scheduler #(
        .DATA_SIZE      (16),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .mod_data    (mod_data),
        .mod_enable  (mod_enable),
        .mod_done    (mod_done),
        .clr_err     (clr_err),
        .busy        (busy),
        .grant       (grant),
        .err_timeout (err_timeout),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 2'b00 && n < 60);
        if (req_ready == 2'b00) bound_expired("wait_ready");
    endtask

    task automatic wait_enable(input logic level, input int limit);
        int n = 0;
        while (mod_enable !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (mod_enable !== level) bound_expired("wait_enable");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) bound_expired("wait_idle");
    endtask

    task automatic model_reset();
        last_m = 1'b1;
        err_m  = 1'b0;
        fc_m   = '0;
    endtask

    // Adds requests, predicts the winner and frame outcome, then drives the frame.
    // k: ACTIVE cycle on which mod_done pulses (0 = never).
    task automatic run_frame(input logic [1:0] add, input logic [15:0] d0, input logic [15:0] d1,
                             input int k, input bit clr, input bit stray, input bit abort);
        exp_t e;
        logic w;
        bit   to;
        if (add[0] && !pending[0]) begin pending[0] = 1'b1; pdata[0] = d0; end
        if (add[1] && !pending[1]) begin pending[1] = 1'b1; pdata[1] = d1; end
        if (pending == 2'b00)      begin pending[0] = 1'b1; pdata[0] = d0; end
        w      = (pending == 2'b11) ? ~last_m : pending[1];
        last_m = w;
        to     = (k == 0) || (k > TO);
        e.ready      = w ? 2'b10 : 2'b01;
        e.grant      = w;
        e.data       = pdata[w];
        e.active_len = to ? TO : k;
        e.err_active = err_m && !clr;
        e.err_gap    = to ? 1'b1 : e.err_active;
        e.abort      = abort;
        if (!abort) begin
            err_m = e.err_gap;
            if (!to && fc_m != 16'hFFFF) fc_m++;
        end
        e.fc = fc_m;
        exp_q.push_back(e);
        req_data0 = pdata[0];
        req_data1 = pdata[1];
        req_valid = pending;
        wait_ready();
        if (!abort) begin
            req_valid[w] = 1'b0;
            pending[w]   = 1'b0;
        end
        if (clr) clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        wait_enable(1'b1, 10);
        if (abort) begin
            repeat (9) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("rst_enable", 32'(mod_enable), 32'd0);
            check("rst_data",   32'(mod_data),   32'd0);
            check("rst_ready",  32'(req_ready),  32'd0);
            check("rst_busy",   32'(busy),       32'd0);
            check("rst_grant",  32'(grant),      32'd0);
            check("rst_err",    32'(err_timeout), 32'd0);
            check("rst_fc",     32'(frame_count), 32'd0);
            reset = 1'b0;
            model_reset();
            return;
        end
        if (k != 0) begin
            repeat (k - 1) @(negedge clk);
            mod_done = 1'b1;
            @(negedge clk);
            mod_done = 1'b0;
        end
        wait_enable(1'b0, TO + 10);
        if (stray) begin
            repeat (2) @(negedge clk);
            mod_done = 1'b1;
            @(negedge clk);
            mod_done = 1'b0;
        end
    endtask

    // Monitor: each ready pulse pops one expected frame and follows it to IDLE.
    initial begin : monitor
        exp_t e;
        int   n;
        int   g;
        bit   unstable;
        @(negedge clk);
        while (reset !== 1'b0) @(negedge clk);
        forever begin
            @(negedge clk);
            if (req_ready != 2'b00 && reset === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'(req_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("load_ready",  32'(req_ready),  32'(e.ready));
                    check("load_grant",  32'(grant),      32'(e.grant));
                    check("load_data",   32'(mod_data),   32'(e.data));
                    check("load_enable", 32'(mod_enable), 32'd0);
                    check("load_busy",   32'(busy),       32'd1);
                    if (!e.abort) begin
                        @(negedge clk);
                        check("active_err", 32'(err_timeout), 32'(e.err_active));
                        n = 0;
                        unstable = 1'b0;
                        while (mod_enable === 1'b1 && n < TO + 5) begin
                            n++;
                            if (mod_data !== e.data) unstable = 1'b1;
                            @(negedge clk);
                        end
                        check("active_len", 32'(n), 32'(e.active_len));
                        check("gap_err",    32'(err_timeout), 32'(e.err_gap));
                        check("gap_fc",     32'(frame_count), 32'(e.fc));
                        g = 0;
                        while (busy === 1'b1 && mod_enable === 1'b0 && g < 300) begin
                            g++;
                            if (mod_data !== e.data) unstable = 1'b1;
                            @(negedge clk);
                        end
                        check("data_stable", 32'(unstable), 32'd0);
                        check("gap_len",     32'(g), 32'(GAP));
                        check("idle_after_gap", {31'd0, busy}, 32'd0);
                        check("idle_enable",    {31'd0, mod_enable}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0] add;
        int         k;
        int         sel;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        mod_done  = 1'b0;
        clr_err   = 1'b0;
        pdata[0]  = '0;
        pdata[1]  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),        32'd0);
        check("reset_enable", 32'(mod_enable),  32'd0);
        check("reset_grant",  32'(grant),       32'd0);
        check("reset_fc",     32'(frame_count), 32'd0);
        check("reset_err",    32'(err_timeout), 32'd0);
        check("reset_data",   32'(mod_data),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray done while idle must do nothing.
        mod_done = 1'b1;
        @(negedge clk);
        mod_done = 1'b0;
        @(negedge clk);
        check("stray_idle_busy", 32'(busy),        32'd0);
        check("stray_idle_fc",   32'(frame_count), 32'd0);

        // Lone requester 0, 100-cycle frame, stray done during the gap.
        run_frame(2'b01, 16'hA5A5, 16'h0000, 100, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("single_fc", 32'(frame_count), 32'd1);

        // Restart so the both-valid run begins with requester 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_reset_fc", 32'(frame_count), 32'd0);

        // Both requesters held: grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            run_frame(2'b11, 16'($urandom), 16'($urandom), 5 + int'($urandom_range(0, 20)),
                      1'b0, 1'b0, 1'b0);
        end
        run_frame(2'b00, 16'h0, 16'h0, 7, 1'b0, 1'b0, 1'b0);

        // Timeout, then done exactly on the timeout cycle with a clear.
        run_frame(2'b10, 16'h0, 16'h1234, 0, 1'b0, 1'b0, 1'b0);
        run_frame(2'b01, 16'h5678, 16'h0, TO, 1'b1, 1'b0, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 25; i++) begin
            add = 2'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       k = int'($urandom_range(1, 40));
            else if (sel == 7) k = TO;
            else if (sel == 8) k = 0;
            else               k = TO + int'($urandom_range(1, 2));
            run_frame(add, 16'($urandom), 16'($urandom), k,
                      err_m && ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), 1'b0);
        end

        // Reset on ACTIVE cycle 10 with both requesters held, then drain.
        run_frame(2'b11, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0, 1'b1);
        run_frame(2'b00, 16'h0, 16'h0, 12, 1'b0, 1'b0, 1'b0);
        run_frame(2'b00, 16'h0, 16'h0, 9, 1'b0, 1'b0, 1'b0);

        wait_idle();
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_fc",  32'(frame_count), 32'(fc_m));
        check("final_err", 32'(err_timeout), 32'(err_m));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin : watchdog
        #2000000;
        bound_expired("global_time_limit");
    end

endmodule
